// File: rtl/pixel_framebuffer.sv
`default_nettype none
// ============================================================================
//  Module   : pixel_framebuffer
//  Purpose  : 160x120x3 frame store sitting on the painter's pixel-write
//             interface. Single-pixel plots are written into an inferred
//             simple dual-port RAM, a raster scan-out port streams the stored
//             pixels in row-major order, and a clear sequencer blanks the
//             whole frame to 3'b000 one location per cycle.
//  Ports    : CLOCK_50     - system clock, rising edge
//             resetn       - asynchronous active-low reset
//             plot/x/y/colour - pixel write strobe, column, row, colour
//             clear_req    - start a full-frame clear
//             pix_en       - scan-out tick, reads the next raster pixel
//             busy         - high while the clear sequencer owns the RAM
//             plot_dropped - one-cycle pulse for a plot that was not written
//             out_valid/out_x/out_y/out_colour/out_sof - scan-out result
//  Revision : 1.0  initial release
// ============================================================================
module pixel_framebuffer (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic       plot,
    input  logic [7:0] x,
    input  logic [6:0] y,
    input  logic [2:0] colour,
    input  logic       clear_req,
    input  logic       pix_en,
    output logic       busy,
    output logic       plot_dropped,
    output logic       out_valid,
    output logic [7:0] out_x,
    output logic [6:0] out_y,
    output logic [2:0] out_colour,
    output logic       out_sof
);

    localparam int          c_depth     = 19200;
    localparam logic [7:0]  c_width     = 8'd160;
    localparam logic [6:0]  c_height    = 7'd120;
    localparam logic [7:0]  c_last_x    = 8'd159;
    localparam logic [6:0]  c_last_y    = 7'd119;
    localparam logic [14:0] c_last_addr = 15'd19199;

    localparam logic [0:0]  c_st_idle   = 1'b0;
    localparam logic [0:0]  c_st_clear  = 1'b1;

    // Control FSM and clear sequencer
    logic [0:0]  r_state;
    logic [0:0]  w_state_nxt;
    logic [14:0] r_clr_addr;
    logic [14:0] w_clr_addr_nxt;

    // Write port
    logic        w_we;
    logic [14:0] w_waddr;
    logic [2:0]  w_wdata;
    logic        w_drop;
    logic        w_in_range;
    logic [14:0] w_plot_addr;
    logic        r_plot_dropped;

    // Scan-out
    logic [7:0]  r_sx;
    logic [6:0]  r_sy;
    logic [14:0] w_scan_addr;
    logic        r_out_valid;
    logic        r_out_sof;
    logic [7:0]  r_out_x;
    logic [6:0]  r_out_y;
    logic        r_have_data;
    logic [2:0]  r_rd_data;

    logic [2:0]  r_mem [0:c_depth-1];

    // y*160 + x as y*128 + y*32 + x
    assign w_plot_addr = 15'({y, 7'b0}) + 15'({y, 5'b0}) + 15'(x);
    assign w_scan_addr = 15'({r_sy, 7'b0}) + 15'({r_sy, 5'b0}) + 15'(r_sx);
    assign w_in_range  = (x < c_width) && (y < c_height);

    // ------------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------------
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_state        <= c_st_idle;
            r_clr_addr     <= 15'd0;
            r_plot_dropped <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_clr_addr     <= w_clr_addr_nxt;
            r_plot_dropped <= w_drop;
        end
    end

    // ------------------------------------------------------------------------
    // FSM next state and write-port arbitration. Clear always wins over plot,
    // including the cycle in which clear_req is accepted.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_clr_addr_nxt = r_clr_addr;
        w_we           = 1'b0;
        w_waddr        = w_plot_addr;
        w_wdata        = colour;
        w_drop         = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (clear_req) begin
                    w_state_nxt    = c_st_clear;
                    w_clr_addr_nxt = 15'd0;
                    w_drop         = plot;
                end else if (plot) begin
                    if (w_in_range) begin
                        w_we = 1'b1;
                    end else begin
                        w_drop = 1'b1;
                    end
                end
            end
            c_st_clear: begin
                w_we    = 1'b1;
                w_waddr = r_clr_addr;
                w_wdata = 3'b000;
                w_drop  = plot;
                if (r_clr_addr == c_last_addr) begin
                    w_state_nxt    = c_st_idle;
                    w_clr_addr_nxt = 15'd0;
                end else begin
                    w_clr_addr_nxt = r_clr_addr + 15'd1;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Frame RAM: no reset so it maps onto block RAM. Read-before-write on a
    // shared address falls out of the non-blocking semantics.
    // ------------------------------------------------------------------------
    always_ff @(posedge CLOCK_50) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
        if (pix_en) begin
            r_rd_data <= r_mem[w_scan_addr];
        end
    end

    // ------------------------------------------------------------------------
    // Raster counters and scan-out output registers
    // ------------------------------------------------------------------------
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_sx        <= 8'd0;
            r_sy        <= 7'd0;
            r_out_valid <= 1'b0;
            r_out_sof   <= 1'b0;
            r_out_x     <= 8'd0;
            r_out_y     <= 7'd0;
            r_have_data <= 1'b0;
        end else begin
            r_out_valid <= pix_en;
            r_out_sof   <= pix_en && (r_sx == 8'd0) && (r_sy == 7'd0);
            if (pix_en) begin
                r_out_x     <= r_sx;
                r_out_y     <= r_sy;
                r_have_data <= 1'b1;
                if (r_sx == c_last_x) begin
                    r_sx <= 8'd0;
                    r_sy <= (r_sy == c_last_y) ? 7'd0 : r_sy + 7'd1;
                end else begin
                    r_sx <= r_sx + 8'd1;
                end
            end
        end
    end

    // The RAM read register has no reset; r_have_data masks it to zero
    // until the first read after reset has landed.
    assign out_colour   = r_have_data ? r_rd_data : 3'b000;
    assign busy         = (r_state == c_st_clear);
    assign plot_dropped = r_plot_dropped;
    assign out_valid    = r_out_valid;
    assign out_x        = r_out_x;
    assign out_y        = r_out_y;
    assign out_sof      = r_out_sof;

endmodule
`default_nettype wire

// File: tb/tb_pixel_framebuffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pixel_framebuffer
//  Purpose  : Self-checking bench for pixel_framebuffer. A vector table drives
//             single plots; hand-written sequences cover clear timing, raster
//             wrap, scan gaps and reset in the middle of a clear.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pixel_framebuffer;

    logic       CLOCK_50;
    logic       resetn;
    logic       plot;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       clear_req;
    logic       pix_en;
    logic       busy;
    logic       plot_dropped;
    logic       out_valid;
    logic [7:0] out_x;
    logic [6:0] out_y;
    logic [2:0] out_colour;
    logic       out_sof;

    pixel_framebuffer dut (
        .CLOCK_50     (CLOCK_50),
        .resetn       (resetn),
        .plot         (plot),
        .x            (x),
        .y            (y),
        .colour       (colour),
        .clear_req    (clear_req),
        .pix_en       (pix_en),
        .busy         (busy),
        .plot_dropped (plot_dropped),
        .out_valid    (out_valid),
        .out_x        (out_x),
        .out_y        (out_y),
        .out_colour   (out_colour),
        .out_sof      (out_sof)
    );

    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        logic       plot;
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] colour;
        logic       exp_drop;
    } vec_t;

    vec_t       vecs [0:5];
    logic [2:0] exp_mem [0:19199];
    int         cap_x [0:19200];
    int         cap_y [0:19200];
    int         cap_c [0:19200];
    int         cap_s [0:19200];
    int         bx;
    int         by;
    int         n_total;
    int         n_pass;

    task automatic tick;
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic model_clear;
        for (int i = 0; i < 19200; i++) exp_mem[i] = 3'b000;
    endtask

    // Issue n consecutive pix_en ticks, compare each result with the model
    // and the bench's own raster position, and record what came back.
    task automatic scan(input int n, output int errs, output int sofs);
        logic [2:0] ec;
        logic       es;
        errs = 0;
        sofs = 0;
        for (int i = 0; i < n; i++) begin
            pix_en = 1'b1;
            tick();
            ec = exp_mem[by * 160 + bx];
            es = (bx == 0 && by == 0) ? 1'b1 : 1'b0;
            cap_x[i] = int'(out_x);
            cap_y[i] = int'(out_y);
            cap_c[i] = int'(out_colour);
            cap_s[i] = int'(out_sof);
            if (out_valid !== 1'b1 || out_x !== 8'(bx) || out_y !== 7'(by) ||
                out_colour !== ec || out_sof !== es) begin
                errs++;
                if (errs <= 3)
                    $display("scan diff at (%0d,%0d): v=%b x=%0d y=%0d c=%0d sof=%b want c=%0d sof=%b",
                             bx, by, out_valid, out_x, out_y, out_colour, out_sof, ec, es);
            end
            if (out_sof === 1'b1) sofs++;
            if (bx == 159) begin
                bx = 0;
                by = (by == 119) ? 0 : by + 1;
            end else begin
                bx = bx + 1;
            end
        end
        pix_en = 1'b0;
    endtask

    initial begin
        int errs;
        int sofs;
        int cnt;

        n_total = 0;
        n_pass  = 0;
        bx = 0;
        by = 0;

        vecs[0] = '{1'b1, 8'd5,   7'd7,   3'b010, 1'b0};
        vecs[1] = '{1'b1, 8'd160, 7'd0,   3'b111, 1'b1};
        vecs[2] = '{1'b1, 8'd0,   7'd120, 3'b111, 1'b1};
        vecs[3] = '{1'b1, 8'd255, 7'd127, 3'b101, 1'b1};
        vecs[4] = '{1'b0, 8'd160, 7'd0,   3'b111, 1'b0};
        vecs[5] = '{1'b1, 8'd159, 7'd119, 3'b100, 1'b0};

        resetn    = 1'b0;
        plot      = 1'b0;
        x         = 8'd0;
        y         = 7'd0;
        colour    = 3'b000;
        clear_req = 1'b0;
        pix_en    = 1'b0;

        // Reset values
        tick(); tick(); tick();
        check("rst_busy",         32'(busy),         0);
        check("rst_plot_dropped", 32'(plot_dropped), 0);
        check("rst_out_valid",    32'(out_valid),    0);
        check("rst_out_x",        32'(out_x),        0);
        check("rst_out_y",        32'(out_y),        0);
        check("rst_out_colour",   32'(out_colour),   0);
        check("rst_out_sof",      32'(out_sof),      0);
        resetn = 1'b1;
        tick();

        // Initial clear: busy for exactly 19200 cycles
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        cnt = 0;
        while (busy === 1'b1 && cnt < 20000) begin
            cnt++;
            tick();
        end
        check("clear1_busy_cycles", 32'(cnt), 19200);
        model_clear();

        // Table-driven single plots
        for (int i = 0; i < 6; i++) begin
            plot   = vecs[i].plot;
            x      = vecs[i].x;
            y      = vecs[i].y;
            colour = vecs[i].colour;
            tick();
            plot = 1'b0;
            check($sformatf("vec%0d_dropped", i), 32'(plot_dropped), 32'(vecs[i].exp_drop));
            if (vecs[i].plot && !vecs[i].exp_drop)
                exp_mem[int'(vecs[i].y) * 160 + int'(vecs[i].x)] = vecs[i].colour;
            if (vecs[i].exp_drop) begin
                tick();
                check($sformatf("vec%0d_drop_pulse_end", i), 32'(plot_dropped), 0);
            end
        end

        // Full frame scan: only (5,7) and (159,119) coloured, one sof
        scan(19200, errs, sofs);
        check("scan1_errs", 32'(errs), 0);
        check("scan1_sof_count", 32'(sofs), 1);
        check("scan1_pix_5_7", 32'(cap_c[7 * 160 + 5]), 32'(3'b010));

        // clear_req and plot in the same IDLE cycle: plot dropped
        clear_req = 1'b1;
        plot      = 1'b1;
        x         = 8'd2;
        y         = 7'd2;
        colour    = 3'b111;
        tick();
        clear_req = 1'b0;
        plot      = 1'b0;
        check("clear_plot_same_cycle_dropped", 32'(plot_dropped), 1);
        check("clear2_busy_start", 32'(busy), 1);

        // During the clear: a plot is dropped and a second clear_req is ignored
        cnt = 0;
        while (busy === 1'b1 && cnt < 20000) begin
            cnt++;
            plot      = (cnt == 50);
            x         = 8'd1;
            y         = 7'd1;
            colour    = 3'b010;
            clear_req = (cnt == 100);
            tick();
            plot      = 1'b0;
            clear_req = 1'b0;
            if (cnt == 50) check("plot_in_clear_dropped", 32'(plot_dropped), 1);
        end
        check("clear2_busy_cycles", 32'(cnt), 19200);
        model_clear();

        // Continuous scan of 19201 pixels across every wrap
        scan(19201, errs, sofs);
        check("scan2_errs", 32'(errs), 0);
        check("scan2_sof_count", 32'(sofs), 2);
        check("scan2_pix_2_2", 32'(cap_c[2 * 160 + 2]), 0);
        check("scan2_pix_1_1", 32'(cap_c[160 + 1]), 0);
        check("wrap_158_x", 32'(cap_x[158]), 158);
        check("wrap_159_x", 32'(cap_x[159]), 159);
        check("wrap_159_y", 32'(cap_y[159]), 0);
        check("wrap_row_x", 32'(cap_x[160]), 0);
        check("wrap_row_y", 32'(cap_y[160]), 1);
        check("wrap_end_x", 32'(cap_x[19199]), 159);
        check("wrap_end_y", 32'(cap_y[19199]), 119);
        check("wrap_frame_x", 32'(cap_x[19200]), 0);
        check("wrap_frame_y", 32'(cap_y[19200]), 0);
        check("wrap_frame_sof", 32'(cap_s[19200]), 1);

        // Gap in pix_en: outputs hold, position holds
        tick();
        check("gap_valid", 32'(out_valid), 0);
        check("gap_hold_x", 32'(out_x), 0);
        check("gap_hold_y", 32'(out_y), 0);
        tick();
        tick();
        pix_en = 1'b1;
        tick();
        pix_en = 1'b0;
        check("gap_resume_valid", 32'(out_valid), 1);
        check("gap_resume_x", 32'(out_x), 1);
        check("gap_resume_y", 32'(out_y), 0);

        // Seed a few low pixels, then reset 100 cycles into a clear
        plot = 1'b1;
        x = 8'd3;   y = 7'd0; colour = 3'b101; tick(); exp_mem[3]   = 3'b101;
        x = 8'd50;  y = 7'd0; colour = 3'b110; tick(); exp_mem[50]  = 3'b110;
        x = 8'd150; y = 7'd0; colour = 3'b011; tick(); exp_mem[150] = 3'b011;
        plot = 1'b0;
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        pix_en    = 1'b1;
        for (int i = 0; i < 100; i++) tick();
        check("midclear_busy_before_rst", 32'(busy), 1);
        check("midclear_valid_before_rst", 32'(out_valid), 1);
        resetn = 1'b0;
        pix_en = 1'b0;
        #1;
        check("midclear_rst_busy", 32'(busy), 0);
        check("midclear_rst_valid", 32'(out_valid), 0);
        tick();
        tick();
        check("midclear_rst_held_busy", 32'(busy), 0);
        resetn = 1'b1;
        for (int i = 0; i < 100; i++) exp_mem[i] = 3'b000;

        // Plot straight after release, then read the first row
        plot   = 1'b1;
        x      = 8'd10;
        y      = 7'd0;
        colour = 3'b111;
        tick();
        plot = 1'b0;
        check("post_rst_plot_not_dropped", 32'(plot_dropped), 0);
        exp_mem[10] = 3'b111;
        bx = 0;
        by = 0;
        scan(160, errs, sofs);
        check("post_rst_first_x", 32'(cap_x[0]), 0);
        check("post_rst_first_y", 32'(cap_y[0]), 0);
        check("post_rst_first_sof", 32'(cap_s[0]), 1);
        check("post_rst_row_errs", 32'(errs), 0);
        check("post_rst_pix_3", 32'(cap_c[3]), 0);
        check("post_rst_pix_10", 32'(cap_c[10]), 32'(3'b111));
        check("post_rst_pix_150", 32'(cap_c[150]), 32'(3'b011));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
